layer_loader: RTL and testbench
===============================

Name: layer_loader

Overview:
- Write-back stage that services `load_en` from the network control FSM.
- Snapshots the activated neuron outputs of the layer just computed.
- Streams them one per cycle into the layer-input RAM at the next layer's address window, then pulses `load_done` so the FSM can leave LOAD.
- Tracks which layer is being written; address windows are contiguous after the 784 input pixels.

Parameters:
- NO_HL, 2, number of hidden layers
- NO_NIL, 784, input-layer neurons (RAM words 0..NO_NIL-1)
- NO_NHL, 28, neurons per hidden layer
- NO_NOL, 10, output-layer neurons
- DW, 8, activation word width
- AW, 11, RAM address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous start-of-inference clear; pulse with `start`
- load_en  in  1  level request from control FSM
- act_data  in  NO_NHL*DW  activated outputs; lane i = bits [i*DW +: DW]
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  DW  RAM write data
- load_done  out  1  one-cycle completion pulse
- layer_idx  out  $clog2(NO_HL+1)  layer currently owed a write-back (0..NO_HL)
- final_load  out  1  high while writing the output layer

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, layer_idx=0, snapshot and counter 0. All outputs are registered.
- Count N = NO_NHL when layer_idx<NO_HL; otherwise N = NO_NOL, using lanes 0..NO_NOL-1.
- Base address = NO_NIL + layer_idx*NO_NHL. Defaults give 784, 812, 840.
- IDLE:
  - On edge k with load_en=1: snapshot <= act_data, cnt <= 0, go WRITE.
  - load_en=0: stay; wr_en=0.
- WRITE:
  - Each cycle: wr_en=1, wr_addr=base+cnt, wr_data=snapshot lane cnt.
  - First write is visible in cycle k+1; the last (cnt=N-1) in cycle k+N, then go DONE.
- DONE (one cycle, k+N+1):
  - wr_en=0, load_done=1.
  - layer_idx increments; it wraps to 0 after layer NO_HL.
  - Go WAIT.
- WAIT:
  - load_done=0.
  - Return to IDLE once load_en=0. A load_en held high never retriggers a second load.
- Latency from request to `load_done`: N+1 cycles (29 hidden, 11 output with defaults).
- final_load: high in WRITE and DONE when layer_idx==NO_HL.
- load_en dropping mid-WRITE is ignored; the transfer completes.
- act_data changes after capture do not affect the written data.
- clr:
  - Wins over everything except reset.
  - Next edge: state=IDLE, layer_idx=0, wr_en=0, load_done=0.
  - A partially written window is abandoned.
  - clr and load_en in the same IDLE cycle: clr wins, no capture.
- Address arithmetic is AW bits. Elaboration asserts NO_NIL+NO_HL*NO_NHL+NO_NOL <= 2**AW and NO_NOL <= NO_NHL.
- Reset mid-WRITE: wr_en drops asynchronously, no further writes.

Decomposition:
- Shared package `nn_pkg`:
  - network-size constants (NO_HL, NO_NIL, NO_NHL, NO_NOL, DW, AW)
  - function layer_base(idx)
  - loader state encoding (IDLE, WRITE, DONE, WAIT, one-hot)
- No sub-module needed. The lane-select mux is inline; a shift-register snapshot is an acceptable alternative, with identical outputs.

Test Plan:
- Reset, then load_en high with act_data lane i = i+1 -> wr_en high for 28 cycles, wr_addr 784..811, wr_data 1..28; load_done single pulse in cycle 29; layer_idx 0->1.
- Three consecutive loads -> windows 784..811, 812..839, then 840..849 with final_load=1 and only lanes 0..9 written; layer_idx returns to 0; exactly three load_done pulses.
- Hold load_en high 10 cycles after load_done -> no extra writes and no second pulse; dropping then re-raising load_en starts the next layer.
- Change act_data every cycle during WRITE and drop load_en mid-write -> written data equals the capture-edge snapshot; all 28 writes complete.
- Assert clr at write 5 of layer 1 -> wr_en low next cycle, layer_idx=0; the next load writes at 784.
- Pull rst low mid-WRITE -> wr_en, load_done and layer_idx are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared network-size constants, loader state encoding and address helper.
//   NO_HL  : number of hidden layers
//   NO_NIL : input-layer neurons (RAM words 0..NO_NIL-1)
//   NO_NHL : neurons per hidden layer
//   NO_NOL : output-layer neurons
//   DW/AW  : activation word width / RAM address width
package nn_pkg;

    localparam int unsigned NO_HL  = 2;
    localparam int unsigned NO_NIL = 784;
    localparam int unsigned NO_NHL = 28;
    localparam int unsigned NO_NOL = 10;
    localparam int unsigned DW     = 8;
    localparam int unsigned AW     = 11;

    // layer index width (0..NO_HL) and write-counter width (0..NO_NHL-1)
    localparam int unsigned LW = $clog2(NO_HL + 1);
    localparam int unsigned CW = $clog2(NO_NHL);

    // highest RAM word touched plus one
    localparam int unsigned ADDR_SPAN = NO_NIL + NO_HL * NO_NHL + NO_NOL;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        WRITE = 4'b0010,
        DONE  = 4'b0100,
        WAIT  = 4'b1000
    } loader_state_t;

    // First RAM word of the window owned by layer idx.
    function automatic logic [AW-1:0] layer_base(input logic [LW-1:0] idx);
        return AW'(NO_NIL) + AW'(idx) * AW'(NO_NHL);
    endfunction

endpackage

// File: rtl/layer_loader.sv
// Write-back stage: snapshots the activated outputs of the layer just computed
// and streams them one word per cycle into the layer-input RAM at the next
// layer's address window, then pulses load_done.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   clr        : synchronous start-of-inference clear
//   load_en    : level request from the control FSM
//   act_data   : activated outputs, lane i = act_data[i*DW +: DW]
//   wr_en      : RAM write strobe
//   wr_addr    : RAM write address
//   wr_data    : RAM write data
//   load_done  : one-cycle completion pulse
//   layer_idx  : layer currently owed a write-back (0..NO_HL)
//   final_load : high while writing the output layer
module layer_loader
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load_en,
    input  logic [NO_NHL*DW-1:0] act_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    output logic                 load_done,
    output logic [LW-1:0]        layer_idx,
    output logic                 final_load
);

    // elaboration-time sanity on the address map
    if (ADDR_SPAN > (32'd1 << AW)) begin : g_addr_overflow
        $error("layer_loader: address windows exceed the RAM address space");
    end
    if (NO_NOL > NO_NHL) begin : g_lane_overflow
        $error("layer_loader: output layer wider than the activation bus");
    end

    loader_state_t        state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    logic [NO_NHL*DW-1:0] snap_q, snap_n;
    logic [LW-1:0]        layer_n;
    logic                 wr_en_n;
    logic [AW-1:0]        wr_addr_n;
    logic [DW-1:0]        wr_data_n;
    logic                 load_done_n;
    logic                 final_n;

    logic [AW-1:0]        base;
    logic [CW-1:0]        last_cnt;
    logic                 is_final;

    // window geometry for the layer currently owed a write-back
    always_comb begin
        is_final = (layer_idx == LW'(NO_HL));
        base     = layer_base(layer_idx);
        last_cnt = is_final ? CW'(NO_NOL - 1) : CW'(NO_NHL - 1);
    end

    // state register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            snap_q     <= '0;
            layer_idx  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            load_done  <= 1'b0;
            final_load <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            snap_q     <= snap_n;
            layer_idx  <= layer_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            load_done  <= load_done_n;
            final_load <= final_n;
        end
    end

    // next-state and next-output logic; outputs are computed one cycle ahead
    // so the registered strobe lines up with the written word
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        snap_n      = snap_q;
        layer_n     = layer_idx;
        wr_en_n     = 1'b0;
        wr_addr_n   = '0;
        wr_data_n   = '0;
        load_done_n = 1'b0;
        final_n     = 1'b0;

        if (clr) begin
            state_n = IDLE;
            cnt_n   = '0;
            layer_n = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_n   = WRITE;
                        cnt_n     = '0;
                        snap_n    = act_data;
                        wr_en_n   = 1'b1;
                        wr_addr_n = base;
                        // lane 0 comes straight from the bus on the capture edge
                        wr_data_n = act_data[DW-1:0];
                        final_n   = is_final;
                    end
                end
                WRITE: begin
                    if (cnt_q == last_cnt) begin
                        state_n     = DONE;
                        load_done_n = 1'b1;
                        final_n     = is_final;
                        layer_n     = is_final ? '0 : layer_idx + LW'(1);
                    end else begin
                        cnt_n     = cnt_q + CW'(1);
                        wr_en_n   = 1'b1;
                        wr_addr_n = base + AW'(cnt_n);
                        wr_data_n = snap_q[32'(cnt_n) * DW +: DW];
                        final_n   = is_final;
                    end
                end
                DONE: begin
                    state_n = WAIT;
                end
                WAIT: begin
                    // a held request must be released before the next load
                    if (!load_en) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_loader.sv
`timescale 1ns/1ps
module tb_layer_loader;
    import nn_pkg::*;

    localparam int unsigned AD = NO_NHL * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          load_en = 1'b0;
    logic [AD-1:0] act_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          load_done;
    logic [LW-1:0] layer_idx;
    logic          final_load;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int m_layer = 0;

    typedef struct {
        int base;
        int n;
        bit fin;
        int nxt;
    } vec_t;
    vec_t tbl [3];

    layer_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load_en    (load_en),
        .act_data   (act_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .layer_idx  (layer_idx),
        .final_load (final_load)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && load_done) pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AD-1:0] rand_vec();
        logic [AD-1:0] v;
        for (int i = 0; i < int'(NO_NHL); i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [31:0] lane(input logic [AD-1:0] v, input int i);
        return 32'(v[i*DW +: DW]);
    endfunction

    // One load request; clr_at / rst_at abort after that write (0 = never).
    task automatic run_load(input logic [AD-1:0] snap, input int exp_base, input int n,
                            input bit fin, input int nxt, input bit scramble,
                            input bit drop_mid, input int hold, input int clr_at,
                            input int rst_at);
        act_data = snap;
        load_en  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                chk("wr_en", 32'(wr_en), 1);
                chk("wr_addr", 32'(wr_addr), 32'(exp_base + c - 1));
                chk("wr_data", 32'(wr_data), lane(snap, c - 1));
                chk("load_done_low", 32'(load_done), 0);
                chk("final_load", 32'(final_load), 32'(fin));
            end else begin
                exp_pulses++;
                chk("wr_en_done", 32'(wr_en), 0);
                chk("load_done", 32'(load_done), 1);
                chk("layer_idx", 32'(layer_idx), 32'(nxt));
                chk("final_load_done", 32'(final_load), 32'(fin));
            end
            if (c == clr_at) begin
                clr = 1'b1;
                load_en = 1'b0;
                @(posedge clk);
                #1 clr = 1'b0;
                @(negedge clk);
                chk("clr_wr_en", 32'(wr_en), 0);
                chk("clr_layer_idx", 32'(layer_idx), 0);
                chk("clr_load_done", 32'(load_done), 0);
                @(negedge clk);
                chk("clr_no_write", 32'(wr_en), 0);
                return;
            end
            if (c == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_wr_en", 32'(wr_en), 0);
                chk("rst_load_done", 32'(load_done), 0);
                chk("rst_layer_idx", 32'(layer_idx), 0);
                chk("rst_final", 32'(final_load), 0);
                load_en = 1'b0;
                @(negedge clk);
                chk("rst_hold_wr_en", 32'(wr_en), 0);
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            @(posedge clk);
            #1;
            if (scramble) act_data = rand_vec();
            if (drop_mid && c == n / 2) load_en = 1'b0;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_wr_en", 32'(wr_en), 0);
            chk("hold_load_done", 32'(load_done), 0);
        end
        load_en = 1'b0;
        @(negedge clk);
        chk("release_wr_en", 32'(wr_en), 0);
        @(negedge clk);
    endtask

    // Reference expectations derived from the window map.
    task automatic model_load(input logic [AD-1:0] snap, input bit scramble,
                              input bit drop_mid, input int hold);
        int n;
        int nxt;
        n   = (m_layer < int'(NO_HL)) ? int'(NO_NHL) : int'(NO_NOL);
        nxt = (m_layer == int'(NO_HL)) ? 0 : m_layer + 1;
        run_load(snap, int'(NO_NIL) + m_layer * int'(NO_NHL), n, m_layer == int'(NO_HL),
                 nxt, scramble, drop_mid, hold, 0, 0);
        m_layer = nxt;
    endtask

    initial begin
        logic [AD-1:0] inc;
        tbl[0] = '{base: 784, n: 28, fin: 1'b0, nxt: 1};
        tbl[1] = '{base: 812, n: 28, fin: 1'b0, nxt: 2};
        tbl[2] = '{base: 840, n: 10, fin: 1'b1, nxt: 0};
        for (int i = 0; i < int'(NO_NHL); i++) inc[i*DW +: DW] = DW'(i + 1);

        #12;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_load_done", 32'(load_done), 0);
        chk("reset_layer_idx", 32'(layer_idx), 0);
        chk("reset_final", 32'(final_load), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // three consecutive loads from the vector table
        for (int i = 0; i < 3; i++) begin
            run_load((i == 0) ? inc : rand_vec(), tbl[i].base, tbl[i].n, tbl[i].fin,
                     tbl[i].nxt, 1'b0, 1'b0, 0, 0, 0);
        end
        chk("pulses_three", 32'(pulses), 3);
        m_layer = 0;

        // held request, then scrambled bus with load_en dropped mid-write
        model_load(rand_vec(), 1'b0, 1'b0, 10);
        model_load(rand_vec(), 1'b1, 1'b1, 0);
        model_load(rand_vec(), 1'b1, 1'b0, 2);

        // clr during layer 1
        model_load(rand_vec(), 1'b0, 1'b0, 0);
        run_load(rand_vec(), 812, 28, 1'b0, 2, 1'b0, 1'b0, 0, 5, 0);
        m_layer = 0;
        model_load(rand_vec(), 1'b0, 1'b0, 0);

        // clr and load_en together in IDLE: no capture
        @(negedge clk);
        clr = 1'b1;
        load_en = 1'b1;
        act_data = rand_vec();
        @(posedge clk);
        #1 clr = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        chk("clr_vs_load_wr_en", 32'(wr_en), 0);
        chk("clr_vs_load_idx", 32'(layer_idx), 0);
        @(negedge clk);
        chk("clr_vs_load_idle", 32'(wr_en), 0);
        m_layer = 0;

        // asynchronous reset mid-write
        run_load(rand_vec(), 784, 28, 1'b0, 1, 1'b0, 1'b0, 0, 0, 10);
        m_layer = 0;

        // randomized traffic against the window model
        for (int r = 0; r < 6; r++) begin
            model_load(rand_vec(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 4)));
        end

        chk("pulse_count", 32'(pulses), 32'(exp_pulses));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
